// File: rtl/param_adder_pkg.sv
// rtl/param_adder_pkg.sv - shared sizing helpers for the pipelined adder
package param_adder_pkg;

  function automatic int chunk_width(input int width, input int stages);
    return width / ((stages < 1) ? 1 : stages);
  endfunction

  function automatic bit params_ok(input int width, input int stages);
    return (width >= 1) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipe_add_stage.sv
// rtl/pipe_add_stage.sv - one chunk add plus its pipeline register
module pipe_add_stage #(
  parameter int WIDTH = 8,
  parameter int CW    = 4,
  parameter int REM   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             c_in,
  output logic             v_out,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out
);

  localparam int OFF = WIDTH - REM - CW;
  // Only the REM unconsumed upper operand bits survive; the rest are tied to zero.
  localparam logic [WIDTH-1:0] HI_MASK = ~({WIDTH{1'b1}} >> REM);

  logic             v_q, v_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic [CW:0]      chunk;

  always_comb begin
    chunk = {1'b0, a_in[OFF +: CW]} + {1'b0, b_in[OFF +: CW]} + {{CW{1'b0}}, c_in};
    v_d   = v_q;
    a_d   = a_q;
    b_d   = b_q;
    sum_d = sum_q;
    c_d   = c_q;
    if (rdy) begin
      v_d              = up_valid;
      a_d              = a_in & HI_MASK;
      b_d              = b_in & HI_MASK;
      sum_d            = sum_in;
      sum_d[OFF +: CW] = chunk[CW-1:0];
      c_d              = chunk[CW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      c_q   <= 1'b0;
    end else begin
      v_q   <= v_d;
      a_q   <= a_d;
      b_q   <= b_d;
      sum_q <= sum_d;
      c_q   <= c_d;
    end
  end

  assign v_out   = v_q;
  assign a_out   = a_q;
  assign b_out   = b_q;
  assign sum_out = sum_q;
  assign c_out   = c_q;

endmodule

// File: rtl/param_pipe_adder.sv
// rtl/param_pipe_adder.sv - pipelined ripple-carry adder with valid/ready on both sides
module param_pipe_adder
  import param_adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("param_pipe_adder: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
  end

  localparam int CW = chunk_width(WIDTH, STAGES);

  logic [STAGES:0] vld;
  logic [STAGES:0] rdy;
  logic [STAGES:0] cry;
  logic [WIDTH-1:0] a_s   [STAGES+1];
  logic [WIDTH-1:0] b_s   [STAGES+1];
  logic [WIDTH-1:0] sum_s [STAGES+1];

  assign vld[0]   = in_valid;
  assign cry[0]   = cin;
  assign a_s[0]   = a;
  assign b_s[0]   = b;
  assign sum_s[0] = '0;

  // Ready ripples back from the output; an empty stage always accepts.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !vld[k+1] || rdy[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipe_add_stage #(
      .WIDTH (WIDTH),
      .CW    (CW),
      .REM   (WIDTH - (k + 1) * CW)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .rdy      (rdy[k]),
      .up_valid (vld[k]),
      .a_in     (a_s[k]),
      .b_in     (b_s[k]),
      .sum_in   (sum_s[k]),
      .c_in     (cry[k]),
      .v_out    (vld[k+1]),
      .a_out    (a_s[k+1]),
      .b_out    (b_s[k+1]),
      .sum_out  (sum_s[k+1]),
      .c_out    (cry[k+1])
    );
  end

  logic unused_tail;
  assign unused_tail = ^{a_s[STAGES], b_s[STAGES]};

  assign in_ready  = rdy[0];
  assign out_valid = vld[STAGES];
  assign sum       = sum_s[STAGES];
  assign cout      = cry[STAGES];

endmodule

// File: tb/tb_param_pipe_adder.sv
// tb/tb_param_pipe_adder.sv - directed and table-driven checks of param_pipe_adder
module tb_param_pipe_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic       iv8, ir8, ov8, or8, cin8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       iv1, ir1, ov1, or1, a1, b1, cin1, sum1, cout1;
  logic        iv16, ir16, ov16, or16, cin16, cout16;
  logic [15:0] a16, b16, sum16;

  param_pipe_adder #(.WIDTH(8), .STAGES(2)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8),
    .out_valid(ov8), .out_ready(or8), .sum(sum8), .cout(cout8));

  param_pipe_adder #(.WIDTH(1), .STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1),
    .out_valid(ov1), .out_ready(or1), .sum(sum1), .cout(cout1));

  param_pipe_adder #(.WIDTH(16), .STAGES(4)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(cin16),
    .out_valid(ov16), .out_ready(or16), .sum(sum16), .cout(cout16));

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  exp_t q8[$];
  exp_t q1[$];
  exp_t q16[$];
  vec_t tbl[11];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          lat_chk;
  bit          acc8;
  logic [7:0]  e8_sum;
  logic        e8_cout;
  logic        e1_sum, e1_cout;
  logic [15:0] e16_sum;
  logic        e16_cout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Observe one cycle at the falling edge, then return 1 time unit after the next rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    acc8 = 1'b0;
    if (!rst) begin
      if (ov8 && or8) begin
        if (q8.size() == 0) check("w8 unexpected result", 32'd1, 32'd0);
        else begin
          e = q8.pop_front();
          check("w8 sum/cout", 32'({cout8, sum8}), 32'({e.cout, e.sum[7:0]}));
          if (lat_chk) check("w8 latency", 32'(cyc - e.cyc), 32'd2);
        end
      end
      if (ov1 && or1) begin
        if (q1.size() == 0) check("w1 unexpected result", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          check("w1 sum/cout", 32'({cout1, sum1}), 32'({e.cout, e.sum[0]}));
          if (lat_chk) check("w1 latency", 32'(cyc - e.cyc), 32'd1);
        end
      end
      if (ov16 && or16) begin
        if (q16.size() == 0) check("w16 unexpected result", 32'd1, 32'd0);
        else begin
          e = q16.pop_front();
          check("w16 sum/cout", 32'({cout16, sum16}), 32'({e.cout, e.sum}));
          if (lat_chk) check("w16 latency", 32'(cyc - e.cyc), 32'd4);
        end
      end
      if (iv8 && ir8) begin
        e.sum = {8'h00, e8_sum}; e.cout = e8_cout; e.cyc = cyc;
        q8.push_back(e);
        acc8 = 1'b1;
      end
      if (iv1 && ir1) begin
        e.sum = {15'h0, e1_sum}; e.cout = e1_cout; e.cyc = cyc;
        q1.push_back(e);
      end
      if (iv16 && ir16) begin
        e.sum = e16_sum; e.cout = e16_cout; e.cyc = cyc;
        q16.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input int i);
    a8 = tbl[i].a; b8 = tbl[i].b; cin8 = tbl[i].cin;
    e8_sum = tbl[i].sum; e8_cout = tbl[i].cout;
    iv8 = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 20 && (q8.size() + q1.size() + q16.size()) != 0; n++) tick();
    check(name, 32'(q8.size() + q1.size() + q16.size()), 32'd0);
  endtask

  initial begin
    int idx;
    int n_acc;

    tbl[0]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[1]  = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    tbl[2]  = '{8'h7F, 8'h80, 1'b1, 8'h00, 1'b1};
    tbl[3]  = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0};
    tbl[4]  = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
    tbl[5]  = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1};
    tbl[6]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl[7]  = '{8'h11, 8'h22, 1'b0, 8'h33, 1'b0};
    tbl[8]  = '{8'hF0, 8'h20, 1'b0, 8'h10, 1'b1};
    tbl[9]  = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};
    tbl[10] = '{8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0};

    rst = 1'b1; lat_chk = 1'b0;
    iv8 = 0; or8 = 0; a8 = 0; b8 = 0; cin8 = 0; e8_sum = 0; e8_cout = 0;
    iv1 = 0; or1 = 0; a1 = 0; b1 = 0; cin1 = 0; e1_sum = 0; e1_cout = 0;
    iv16 = 0; or16 = 0; a16 = 0; b16 = 0; cin16 = 0; e16_sum = 0; e16_cout = 0;
    tick();
    tick();
    check("reset w8 out_valid/sum/cout", 32'({ov8, sum8, cout8}), 32'd0);
    check("reset w8 in_ready", 32'(ir8), 32'd1);
    check("reset w1 out_valid/sum/cout/in_ready", 32'({ov1, sum1, cout1, ir1}), 32'b0001);
    check("reset w16 out_valid/sum/cout/in_ready", 32'({ov16, sum16, cout16, ir16}), 32'h1);
    rst = 1'b0;

    // Back-to-back table vectors, unstalled.
    or8 = 1'b1; lat_chk = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive8(i);
      tick();
    end
    iv8 = 1'b0;
    drain("w8 table drained");

    // Backpressure: stall output for 5 cycles with input offered.
    or8 = 1'b0; lat_chk = 1'b0; idx = 7; n_acc = 0;
    for (int n = 0; n < 5; n++) begin
      drive8(idx);
      tick();
      if (acc8) begin idx++; n_acc++; end
    end
    check("stall accepts", 32'(n_acc), 32'd2);
    check("stall in_ready", 32'(ir8), 32'd0);
    check("stall head", 32'({ov8, cout8, sum8}), 32'({1'b1, 1'b0, 8'h33}));
    tick();
    check("stall hold", 32'({ov8, cout8, sum8}), 32'({1'b1, 1'b0, 8'h33}));
    or8 = 1'b1;
    #1;
    check("full accept+emit in_ready", 32'(ir8), 32'd1);
    for (int n = 0; n < 20 && idx < 11; n++) begin
      drive8(idx);
      tick();
      if (acc8) idx++;
    end
    iv8 = 1'b0;
    check("stall all fed", 32'(idx), 32'd11);
    drain("w8 stall drained");

    // Reset with two results in flight.
    or8 = 1'b0; idx = 0;
    for (int n = 0; n < 10 && idx < 2; n++) begin
      drive8(idx);
      tick();
      if (acc8) idx++;
    end
    iv8 = 1'b0;
    check("pre-reset out_valid", 32'(ov8), 32'd1);
    rst = 1'b1;
    tick();
    check("mid reset out_valid/sum/cout", 32'({ov8, sum8, cout8}), 32'd0);
    check("mid reset in_ready", 32'(ir8), 32'd1);
    q8.delete();
    rst = 1'b0; or8 = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick();
      check("no stale after reset", 32'(ov8), 32'd0);
    end

    // WIDTH=1, STAGES=1 exhaustive.
    or1 = 1'b1; lat_chk = 1'b1;
    for (int i = 0; i < 8; i++) begin
      {a1, b1, cin1} = 3'(i);
      e1_sum  = a1 ^ b1 ^ cin1;
      e1_cout = (a1 & b1) | (a1 & cin1) | (b1 & cin1);
      iv1 = 1'b1;
      tick();
    end
    iv1 = 1'b0;
    drain("w1 drained");

    // WIDTH=16, STAGES=4 random.
    or16 = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      cin16 = 1'($urandom);
      {e16_cout, e16_sum} = {1'b0, a16} + {1'b0, b16} + {16'h0, cin16};
      iv16 = 1'b1;
      tick();
    end
    iv16 = 1'b0;
    drain("w16 drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
